demorgan_sweep: RTL and testbench



---
 rtl/demorgan_pkg.sv | 18 +
 rtl/demorgan_vec.sv | 45 ++++
 rtl/demorgan_sweep.sv | 154 +++++++++++++++
 tb/tb_demorgan_sweep.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demorgan_pkg.sv
// demorgan_pkg
// Shared definitions for the DeMorgan exhaustive sweep tester: the sweep
// controller state encoding and the legal range of the operand width.
package demorgan_pkg;

  // Sweep controller states, fixed 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Legal range of the WIDTH parameter of demorgan_sweep.
  localparam int MIN_WIDTH = 1;
  localparam int MAX_WIDTH = 8;

endpackage

// File: rtl/demorgan_vec.sv
// demorgan_vec
// Purely combinational WIDTH-bit DeMorgan gate network. Both sides of each
// DeMorgan identity are produced so the caller can compare them.
// Ports:
//   i_a, i_b     operands A and B
//   i_flt        fault injection: bit 0 of nA&nB is replaced by ~A[0]
//   o_nandnb     nA & nB   (possibly faulted on bit 0)
//   o_norb       ~(A | B)
//   o_nandb      ~(A & B)
//   o_nornb      nA | nB
module demorgan_vec
  import demorgan_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flt,
  output logic [WIDTH-1:0] o_nandnb,
  output logic [WIDTH-1:0] o_norb,
  output logic [WIDTH-1:0] o_nandb,
  output logic [WIDTH-1:0] o_nornb
);

  logic [WIDTH-1:0] w_na;
  logic [WIDTH-1:0] w_nb;

  assign w_na    = ~i_a;
  assign w_nb    = ~i_b;
  assign o_norb  = ~(i_a | i_b);
  assign o_nandb = ~(i_a & i_b);
  assign o_nornb = w_na | w_nb;

  // nA&nB with optional fault on bit 0; ~A[0] differs from the true value
  // only when A[0]=0 and B[0]=1.
  always_comb begin
    o_nandnb = w_na & w_nb;
    if (i_flt) begin
      o_nandnb[0] = ~i_a[0];
    end else begin
      o_nandnb[0] = w_na[0] & w_nb[0];
    end
  end

endmodule

// File: rtl/demorgan_sweep.sv
// demorgan_sweep
// Exhaustive hardware tester for the DeMorgan network: on start it walks all
// 2^(2*WIDTH) operand pairs, checks both identities per pair through a
// two-stage pipeline, counts mismatching pairs and captures the first one.
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_start, i_fault_en     run request (IDLE only), fault enable (latched at start)
//   o_busy, o_done          run in progress, one-cycle completion pulse
//   o_vec_a, o_vec_b        operand pair currently presented
//   o_err_count             mismatching pairs in the last run
//   o_first_err_*           first mismatching pair and its valid flag
module demorgan_sweep
  import demorgan_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_fault_en,
  output logic               o_busy,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_vec_a,
  output logic [WIDTH-1:0]   o_vec_b,
  output logic [2*WIDTH:0]   o_err_count,
  output logic               o_first_err_valid,
  output logic [WIDTH-1:0]   o_first_err_a,
  output logic [WIDTH-1:0]   o_first_err_b
);

  localparam int CW = 2 * WIDTH;
  localparam int EW = CW + 1;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_flt;
  logic             r_p1_mis;
  logic             r_p1_valid;
  logic [WIDTH-1:0] r_p1_a;
  logic [WIDTH-1:0] r_p1_b;

  logic             w_accept;
  logic             w_last;
  logic             w_mismatch;
  logic [WIDTH-1:0] w_nandnb;
  logic [WIDTH-1:0] w_norb;
  logic [WIDTH-1:0] w_nandb;
  logic [WIDTH-1:0] w_nornb;

  assign w_accept = (r_state == IDLE) && i_start;
  assign w_last   = (r_cnt == {CW{1'b1}});
  assign o_vec_a  = r_cnt[CW-1:WIDTH];
  assign o_vec_b  = r_cnt[WIDTH-1:0];

  demorgan_vec #(
    .WIDTH (WIDTH)
  ) u_vec (
    .i_a      (o_vec_a),
    .i_b      (o_vec_b),
    .i_flt    (r_flt),
    .o_nandnb (w_nandnb),
    .o_norb   (w_norb),
    .o_nandb  (w_nandb),
    .o_nornb  (w_nornb)
  );

  assign w_mismatch = |((w_nandnb ^ w_norb) | (w_nandb ^ w_nornb));

  // Sweep controller: state, operand counter, latched fault flag, busy/done.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= {CW{1'b0}};
      r_flt   <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_state <= SWEEP;
            r_cnt   <= {CW{1'b0}};
            r_flt   <= i_fault_en;
            o_busy  <= 1'b1;
          end else begin
            o_busy  <= 1'b0;
          end
        end
        SWEEP: begin
          // The counter parks on all-ones so the last pair stays visible.
          if (w_last) begin
            r_state <= DRAIN;
          end else begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DRAIN: begin
          r_state <= DONE;
          o_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: register the per-pair check; only SWEEP-cycle pairs are valid.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_p1_mis   <= 1'b0;
      r_p1_valid <= 1'b0;
      r_p1_a     <= {WIDTH{1'b0}};
      r_p1_b     <= {WIDTH{1'b0}};
    end else begin
      r_p1_mis   <= w_mismatch;
      r_p1_valid <= (r_state == SWEEP);
      r_p1_a     <= o_vec_a;
      r_p1_b     <= o_vec_b;
    end
  end

  // Stage 2: accumulate mismatches and capture the first failing pair.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_err_count       <= {EW{1'b0}};
      o_first_err_valid <= 1'b0;
      o_first_err_a     <= {WIDTH{1'b0}};
      o_first_err_b     <= {WIDTH{1'b0}};
    end else if (w_accept) begin
      o_err_count       <= {EW{1'b0}};
      o_first_err_valid <= 1'b0;
      o_first_err_a     <= {WIDTH{1'b0}};
      o_first_err_b     <= {WIDTH{1'b0}};
    end else if (r_p1_valid && r_p1_mis) begin
      // Width covers 2^(2*WIDTH), so this can never wrap.
      o_err_count <= o_err_count + {{(EW-1){1'b0}}, 1'b1};
      if (!o_first_err_valid) begin
        o_first_err_valid <= 1'b1;
        o_first_err_a     <= r_p1_a;
        o_first_err_b     <= r_p1_b;
      end
    end
  end

endmodule

// File: tb/tb_demorgan_sweep.sv
module tb_demorgan_sweep;

  typedef struct {
    int cnt;
    bit v;
    int fa;
    int fb;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tb_start = 1'b0;
  logic tb_fault = 1'b0;
  int   sel = 2;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Per-width DUT signals
  logic s1, s2, s8;
  logic b1, b2, b8, d1, d2, d8, v1, v2, v8;
  logic [0:0] a1, vb1, fa1, fb1;
  logic [1:0] a2, vb2, fa2, fb2;
  logic [7:0] a8, vb8, fa8, fb8;
  logic [2:0]  e1;
  logic [4:0]  e2;
  logic [16:0] e8;

  assign s1 = tb_start && (sel == 1);
  assign s2 = tb_start && (sel == 2);
  assign s8 = tb_start && (sel == 8);

  demorgan_sweep #(.WIDTH(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_start(s1), .i_fault_en(tb_fault),
    .o_busy(b1), .o_done(d1), .o_vec_a(a1), .o_vec_b(vb1), .o_err_count(e1),
    .o_first_err_valid(v1), .o_first_err_a(fa1), .o_first_err_b(fb1));
  demorgan_sweep #(.WIDTH(2)) u_dut2 (
    .i_clk(clk), .i_reset(rst), .i_start(s2), .i_fault_en(tb_fault),
    .o_busy(b2), .o_done(d2), .o_vec_a(a2), .o_vec_b(vb2), .o_err_count(e2),
    .o_first_err_valid(v2), .o_first_err_a(fa2), .o_first_err_b(fb2));
  demorgan_sweep #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_reset(rst), .i_start(s8), .i_fault_en(tb_fault),
    .o_busy(b8), .o_done(d8), .o_vec_a(a8), .o_vec_b(vb8), .o_err_count(e8),
    .o_first_err_valid(v8), .o_first_err_a(fa8), .o_first_err_b(fb8));

  // Observation view of the selected instance
  logic g_busy, g_done, g_fev;
  int   g_va, g_vb, g_err, g_fa, g_fb;
  always_comb begin
    g_busy = b2; g_done = d2; g_fev = v2;
    g_va = int'(a2); g_vb = int'(vb2); g_err = int'(e2); g_fa = int'(fa2); g_fb = int'(fb2);
    if (sel == 1) begin
      g_busy = b1; g_done = d1; g_fev = v1;
      g_va = int'(a1); g_vb = int'(vb1); g_err = int'(e1); g_fa = int'(fa1); g_fb = int'(fb1);
    end else if (sel == 8) begin
      g_busy = b8; g_done = d8; g_fev = v8;
      g_va = int'(a8); g_vb = int'(vb8); g_err = int'(e8); g_fa = int'(fa8); g_fb = int'(fb8);
    end
  end

  // Reference: walk every pair in sweep order and evaluate both identities.
  function automatic exp_t model(int w, bit flt);
    exp_t r;
    int mask, a, b, na, nb, t1, t2, t3, t4;
    r.cnt = 0; r.v = 1'b0; r.fa = 0; r.fb = 0;
    mask = (1 << w) - 1;
    for (int k = 0; k < (1 << (2 * w)); k++) begin
      a  = k >> w;
      b  = k & mask;
      na = ~a & mask;
      nb = ~b & mask;
      t1 = na & nb;
      if (flt) t1 = (t1 & ~1) | (na & 1);
      t2 = ~(a | b) & mask;
      t3 = ~(a & b) & mask;
      t4 = na | nb;
      if (((t1 ^ t2) | (t3 ^ t4)) != 0) begin
        r.cnt++;
        if (!r.v) begin r.v = 1'b1; r.fa = a; r.fb = b; end
      end
    end
    return r;
  endfunction

  // Follows one run from edge first_e up to E_{N+2}; caller sits just after E_{first_e}.
  task automatic watch_run(input int w, input int first_e, input int toggle_at);
    int n, got_vec, exp_vec;
    bit seen_done;
    exp_t e;
    n = 1 << (2 * w);
    seen_done = 1'b0;
    e.cnt = -1; e.v = 1'b0; e.fa = 0; e.fb = 0;
    for (int k = first_e; k <= n + 2; k++) begin
      @(negedge clk);
      got_vec = (g_va << w) | g_vb;
      exp_vec = (k < n) ? k : n - 1;
      n_checks++;
      if (g_busy !== (k <= n + 1)) begin
        n_fail++; $display("FAIL busy w=%0d e=%0d: got %0b expected %0b", w, k, g_busy, (k <= n + 1));
      end
      n_checks++;
      if (g_done !== (k == n + 1)) begin
        n_fail++; $display("FAIL done w=%0d e=%0d: got %0b expected %0b", w, k, g_done, (k == n + 1));
      end
      n_checks++;
      if (got_vec !== exp_vec) begin
        n_fail++; $display("FAIL vec w=%0d e=%0d: got %0d expected %0d", w, k, got_vec, exp_vec);
      end
      if (k == 0) begin
        n_checks++;
        if (g_err !== 0 || g_fev !== 1'b0) begin
          n_fail++; $display("FAIL clear_at_start w=%0d: got err=%0d fev=%0b expected 0/0", w, g_err, g_fev);
        end
      end
      if (g_done === 1'b1 && !seen_done) begin
        seen_done = 1'b1;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL scoreboard w=%0d: done with no expected result queued", w);
        end else begin
          e = sb.pop_front();
          if (g_err !== e.cnt || g_fev !== e.v || (e.v && (g_fa !== e.fa || g_fb !== e.fb))) begin
            n_fail++;
            $display("FAIL result w=%0d: got err=%0d fev=%0b a=%0d b=%0d expected err=%0d fev=%0b a=%0d b=%0d",
                     w, g_err, g_fev, g_fa, g_fb, e.cnt, e.v, e.fa, e.fb);
          end
        end
      end
      if (k == n + 2) begin
        n_checks++;
        if (!seen_done) begin
          n_fail++; $display("FAIL done_seen w=%0d: got none expected pulse after E%0d", w, n + 1);
        end else if (g_err !== e.cnt || g_fev !== e.v) begin
          n_fail++; $display("FAIL result_hold w=%0d: got err=%0d fev=%0b expected err=%0d fev=%0b", w, g_err, g_fev, e.cnt, e.v);
        end
      end
      if (k == toggle_at) tb_fault = ~tb_fault;
      if (k < n + 2) @(posedge clk);
    end
  endtask

  task automatic launch(input int w, input bit flt);
    sel = w;
    @(negedge clk);
    tb_fault = flt;
    tb_start = 1'b1;
    sb.push_back(model(w, flt));
    @(posedge clk);
    #1;
    tb_start = 1'b0;
    tb_fault = ~flt;   // later fault_en changes must not matter
  endtask

  task automatic test_reset();
    sel = 2;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({b2, d2, a2, vb2, e2, v2, fa2, fb2} !== '0) begin
      n_fail++; $display("FAIL reset_w2: got %0h expected 0", {b2, d2, a2, vb2, e2, v2, fa2, fb2});
    end
    n_checks++;
    if ({b1, d1, e1, v1, b8, d8, e8, v8, a8, vb8} !== '0) begin
      n_fail++; $display("FAIL reset_w1_w8: got %0h expected 0", {b1, d1, e1, v1, b8, d8, e8, v8, a8, vb8});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (b2 !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_start: got busy=%0b expected 0", b2);
    end
  endtask

  task automatic test_clean_sweep();
    launch(2, 1'b0);
    watch_run(2, 0, -1);
  endtask

  task automatic test_fault_sweep();
    launch(2, 1'b1);
    watch_run(2, 0, -1);
  endtask

  task automatic test_width1();
    launch(1, 1'b1);
    watch_run(1, 0, -1);
  endtask

  task automatic test_reset_mid_sweep();
    launch(2, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (((int'(a2) << 2) | int'(vb2)) !== 6) begin
      n_fail++; $display("FAIL pre_reset_vec: got %0d expected 6", (int'(a2) << 2) | int'(vb2));
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({b2, d2, a2, vb2, e2, v2, fa2, fb2} !== '0) begin
      n_fail++; $display("FAIL reset_mid_sweep: got %0h expected 0", {b2, d2, a2, vb2, e2, v2, fa2, fb2});
    end
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b2 !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got busy=%0b expected 0", b2);
    end
    launch(2, 1'b1);
    watch_run(2, 0, -1);
  endtask

  task automatic test_hold_start();
    sel = 2;
    @(negedge clk);
    tb_fault = 1'b0;
    tb_start = 1'b1;
    sb.push_back(model(2, 1'b0));
    @(posedge clk);
    #1;
    watch_run(2, 0, 5);          // fault_en goes high mid-sweep, start stays high
    sb.push_back(model(2, tb_fault));
    @(posedge clk);
    #1;
    tb_start = 1'b0;
    watch_run(2, 0, -1);
  endtask

  task automatic test_width8();
    launch(8, 1'b1);
    watch_run(8, 0, -1);
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_fault_sweep();
    test_width1();
    test_reset_mid_sweep();
    test_hold_start();
    test_width8();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
